eth_link_sequencer: RTL
=======================

// Module: eth_link_sequencer
//
// PURPOSE
//  Brings up two Ethernet cores and keeps them up. Each port has its own FSM that
//  pulses that core's reset and waits for PCS alignment. After a timeout the FSM
//  retries, and after a set number of failures it gives up. Link drops are debounced
//  before re-training. A round-robin arbiter lets only one core be in reset at a time
//  (the cores share a GT quad). Sits between the Ethernet cores and the AXI status block.
//
// PARAMETERS
//  RESET_CYCLES   100        core-reset pulse width, clk cycles (>=1)
//  DEBOUNCE       1000       consecutive stable cycles to accept eth_up rise or fall (>=1)
//  ALIGN_TIMEOUT  1000000    cycles in ALIGN without debounced alignment before retry
//  MAX_RETRIES    15         failed align attempts before FAIL (1..255)
//
// PORTS
//  clk          in   1   system clock
//  resetn       in   1   reset, asynchronous assert, active-low
//  enable       in   1   1 = sequencer runs; 0 = hold both cores in reset
//  eth_up       in   2   per-port PCS-aligned; already synchronous to clk
//  restart      in   2   per-port 1-cycle pulse; leaves FAIL
//  core_reset   out  2   per-port active-high reset to Ethernet core
//  link_ok      out  2   per-port 1 = state UP
//  give_up      out  2   per-port 1 = state FAIL
//  retries      out  16  {port1[7:0], port0[7:0]} failed-attempt count
//
// BEHAVIOUR
//  Reset values (resetn=0): core_reset=2'b11, link_ok=0, give_up=0, retries=0,
//   all FSMs IDLE, arbiter priority = port 0.
//  Per-port FSM states (all outputs registered):
//   IDLE : core_reset=1. If enable=1, go to REQ next cycle.
//   REQ  : core_reset=1. Raise a request. On grant, go to RESET.
//   RESET: core_reset=1 for exactly RESET_CYCLES cycles, then ALIGN. Token is released
//          on the ALIGN entry cycle.
//   ALIGN: core_reset=0. Two counters run:
//          - stable counter counts consecutive eth_up=1 and clears on eth_up=0.
//          - timer counts cycles since entering ALIGN.
//          Stable counter reaches DEBOUNCE -> UP; retries cleared to 0.
//          Otherwise timer reaches ALIGN_TIMEOUT -> retries+1 (saturates at 255).
//          Then, if new retries >= MAX_RETRIES -> FAIL, else -> REQ.
//          If both happen on the same cycle, UP wins.
//   UP   : core_reset=0, link_ok=1. DEBOUNCE consecutive eth_up=0 -> REQ (retries
//          unchanged). Shorter glitches are ignored; the counter clears on eth_up=1.
//   FAIL : core_reset=1, give_up=1. restart pulse -> REQ, retries cleared.
//          restart in any other state is ignored.
//  enable=0 (sampled synchronously): every FSM goes to IDLE next cycle and the token
//   is revoked, even mid-RESET or mid-UP. core_reset=1 from that cycle on.
//   retries and give_up clear on entering IDLE.
//  Arbiter:
//   - Single token. Grant is registered: request in cycle N -> RESET in cycle N+1
//     at the earliest.
//   - When both ports request on the same cycle, the port with priority wins; priority
//     then passes to the other port.
//   - A sole requester is granted regardless of priority.
//   - No new grant while a port is in RESET.
//  Timer widths: sized with $clog2 of the parameter plus 1. No wrap: counters stop at
//   their terminal value.
//  resetn asserted mid-operation: immediate return to reset values, independent of clk.
//
// TESTING
//  1. enable=1, eth_up=2'b11 constant -> port0 core_reset low after 1+1+RESET_CYCLES
//     cycles; port1 starts RESET only after port0 reaches ALIGN; both link_ok=1
//     DEBOUNCE cycles after their ALIGN entry.
//  2. eth_up[0]=0 forever, MAX_RETRIES=3, ALIGN_TIMEOUT=50 -> retries[7:0] goes
//     1,2,3; give_up[0]=1, core_reset[0]=1; restart[0] pulse -> retries=0, REQ.
//  3. In UP, drop eth_up[1] for DEBOUNCE-1 cycles -> link_ok[1] stays 1;
//     drop for DEBOUNCE cycles -> link_ok[1]=0 and core_reset[1]=1 next cycle.
//  4. Both ports request on the same cycle twice in a row -> first grant port0,
//     second grant port1 (round-robin); never both core_reset low-then-high
//     pulses overlapping.
//  5. enable->0 while port0 is in RESET -> both FSMs IDLE, token free, core_reset=11;
//     enable->1 -> normal bring-up restarts from REQ.
//  6. resetn pulsed low mid-UP between clk edges -> outputs take reset values
//     immediately, without waiting for clk.

Source files
------------

// File: rtl/eth_link_sequencer.sv
// Dual-port Ethernet bring-up sequencer: per-port reset/align FSMs sharing one
// reset token. Ports: clk, resetn, enable, eth_up[1:0], restart[1:0] in;
// core_reset, link_ok, give_up [1:0] and retries[15:0] out.
module eth_link_sequencer #(
  parameter int unsigned RESET_CYCLES  = 100,
  parameter int unsigned DEBOUNCE      = 1000,
  parameter int unsigned ALIGN_TIMEOUT = 1000000,
  parameter int unsigned MAX_RETRIES   = 15
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        enable,
  input  logic [1:0]  eth_up,
  input  logic [1:0]  restart,
  output logic [1:0]  core_reset,
  output logic [1:0]  link_ok,
  output logic [1:0]  give_up,
  output logic [15:0] retries
);

  localparam int unsigned TMAX =
    (ALIGN_TIMEOUT > RESET_CYCLES) ? ALIGN_TIMEOUT : RESET_CYCLES;
  localparam int TW = $clog2(TMAX) + 1;
  localparam int DW = $clog2(DEBOUNCE) + 1;

  localparam logic [TW-1:0] T_MX  = TW'(TMAX);
  localparam logic [TW-1:0] T_RST = TW'(RESET_CYCLES);
  localparam logic [TW-1:0] T_ALN = TW'(ALIGN_TIMEOUT);
  localparam logic [DW-1:0] D_TGT = DW'(DEBOUNCE);
  localparam logic [7:0]    R_MAX = 8'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_RESET,
    S_ALIGN,
    S_UP,
    S_FAIL
  } state_t;

  state_t [1:0]        st_q;
  state_t [1:0]        st_d;
  logic [1:0][TW-1:0]  tmr_q;
  logic [1:0][TW-1:0]  tmr_d;
  logic [1:0][DW-1:0]  deb_q;
  logic [1:0][DW-1:0]  deb_d;
  logic [1:0][7:0]     rty_q;
  logic [1:0][7:0]     rty_d;
  logic                prio_q;
  logic                prio_d;
  logic [1:0]          req;
  logic [1:0]          gnt;
  logic                busy;
  logic [1:0]          core_reset_d;
  logic [1:0]          link_ok_d;
  logic [1:0]          give_up_d;

  function automatic logic [TW-1:0] tinc(input logic [TW-1:0] v);
    return (v >= T_MX) ? v : v + TW'(1);
  endfunction

  function automatic logic [DW-1:0] dinc(input logic [DW-1:0] v);
    return (v >= D_TGT) ? v : v + DW'(1);
  endfunction

  assign req  = {st_q[1] == S_REQ, st_q[0] == S_REQ};
  assign busy = (st_q[0] == S_RESET) || (st_q[1] == S_RESET);

  // Token is implicit: whoever sits in RESET holds it.
  // Priority only rotates on contention.
  always_comb begin
    gnt    = 2'b00;
    prio_d = prio_q;
    if (enable && !busy) begin
      unique case (1'b1)
        (req == 2'b11): begin
          gnt    = prio_q ? 2'b10 : 2'b01;
          prio_d = ~prio_q;
        end
        (req == 2'b01): gnt = 2'b01;
        (req == 2'b10): gnt = 2'b10;
        default: ;
      endcase
    end
  end

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      st_d[p]  = st_q[p];
      tmr_d[p] = tmr_q[p];
      deb_d[p] = deb_q[p];
      rty_d[p] = rty_q[p];
      unique case (st_q[p])
        S_IDLE: st_d[p] = S_REQ;
        S_REQ: begin
          if (gnt[p]) st_d[p] = S_RESET;
        end
        S_RESET: begin
          tmr_d[p] = tinc(tmr_q[p]);
          if (tmr_d[p] >= T_RST) st_d[p] = S_ALIGN;
        end
        S_ALIGN: begin
          tmr_d[p] = tinc(tmr_q[p]);
          deb_d[p] = eth_up[p] ? dinc(deb_q[p]) : '0;
          if (deb_d[p] >= D_TGT) begin
            st_d[p]  = S_UP;
            rty_d[p] = '0;
          end else if (tmr_d[p] >= T_ALN) begin
            rty_d[p] = (rty_q[p] == 8'hff) ?
                       rty_q[p] : rty_q[p] + 8'd1;
            st_d[p]  = (rty_d[p] >= R_MAX) ? S_FAIL : S_REQ;
          end
        end
        S_UP: begin
          deb_d[p] = eth_up[p] ? '0 : dinc(deb_q[p]);
          if (deb_d[p] >= D_TGT) st_d[p] = S_REQ;
        end
        S_FAIL: begin
          if (restart[p]) begin
            st_d[p]  = S_REQ;
            rty_d[p] = '0;
          end
        end
        default: st_d[p] = S_IDLE;
      endcase
      if (!enable) begin
        st_d[p]  = S_IDLE;
        rty_d[p] = '0;
      end
      // Counters restart on every state change.
      if (st_d[p] != st_q[p]) begin
        tmr_d[p] = '0;
        deb_d[p] = '0;
      end
      core_reset_d[p] = (st_d[p] != S_ALIGN) &&
                        (st_d[p] != S_UP);
      link_ok_d[p]    = (st_d[p] == S_UP);
      give_up_d[p]    = (st_d[p] == S_FAIL);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      st_q       <= {S_IDLE, S_IDLE};
      tmr_q      <= '0;
      deb_q      <= '0;
      rty_q      <= '0;
      prio_q     <= 1'b0;
      core_reset <= 2'b11;
      link_ok    <= 2'b00;
      give_up    <= 2'b00;
    end else begin
      st_q       <= st_d;
      tmr_q      <= tmr_d;
      deb_q      <= deb_d;
      rty_q      <= rty_d;
      prio_q     <= prio_d;
      core_reset <= core_reset_d;
      link_ok    <= link_ok_d;
      give_up    <= give_up_d;
    end
  end

  assign retries = {rty_q[1], rty_q[0]};

endmodule
